dmem_arbiter: RTL

Sequencing controller and two-port arbiter for the single-port data memory used by the MEM stage. It shares the memory between the pipeline (CPU port) and a debug/loader port (DBG port). It runs each access as a fixed-latency transaction with an explicit done pulse, and drives a stall to the pipeline while a CPU access is outstanding. It sits between the EX/MEM pipeline register outputs and the data memory instance, in place of the direct MEM-stage connection.

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin sequencer for the single-port MEM-stage data memory
// Each access runs IDLE -> BUSY (MEM_LAT cycles) -> DONE; the CPU port is stalled until its done pulse.
module dmem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic              owner;       // 0 = CPU, 1 = DBG
  logic              last_owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              grant, grant_dbg, busy;

  // On a tie the port that did not own the previous access wins.
  assign grant     = cpu_req | dbg_req;
  assign grant_dbg = dbg_req & (~cpu_req | ~last_owner);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_owner  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt         <= 4'd0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant) begin
            owner      <= grant_dbg;
            last_owner <= grant_dbg;
            we_q       <= grant_dbg ? dbg_we    : cpu_we;
            addr_q     <= grant_dbg ? dbg_addr  : cpu_addr;
            wdata_q    <= grant_dbg ? dbg_wdata : cpu_wdata;
            cnt        <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!we_q) begin
            if (owner) dbg_rdata_q <= mem_rdata;
            else       cpu_rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Write strobe only on the first BUSY cycle so each write commits exactly once.
  assign busy      = (state == BUSY);
  assign mem_read  = busy & ~we_q;
  assign mem_write = busy & we_q & (cnt == CNT_INIT);
  assign mem_addr  = busy ? addr_q  : '0;
  assign mem_wdata = busy ? wdata_q : '0;

  assign cpu_done  = (state == DONE) & ~owner;
  assign dbg_done  = (state == DONE) & owner;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
